// File: rtl/srv32_xif_tracker.sv
// CV-X-IF offload tracker: forwards issues, keeps an in-order queue of accepted
// offloads, turns core retire/kill into XIF commits and routes results to the RF.
module srv32_xif_tracker #(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 4,
    parameter int XLEN     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       core_issue_valid,
    input  logic [31:0]                core_issue_instr,
    input  logic [XLEN-1:0]            core_rs1,
    input  logic [XLEN-1:0]            core_rs2,
    output logic                       core_issue_ready,
    output logic                       core_issue_accept,
    input  logic                       core_commit_valid,
    input  logic                       core_commit_kill,
    output logic                       core_wb_valid,
    output logic [4:0]                 core_wb_rd,
    output logic [XLEN-1:0]            core_wb_data,
    output logic                       stall,
    output logic                       xif_issue_valid,
    input  logic                       xif_issue_ready,
    output logic [31:0]                xif_issue_instr,
    output logic [XLEN-1:0]            xif_issue_rs1,
    output logic [XLEN-1:0]            xif_issue_rs2,
    output logic [ID_WIDTH-1:0]        xif_issue_id,
    input  logic                       xif_resp_accept,
    input  logic                       xif_resp_writeback,
    output logic                       xif_commit_valid,
    output logic [ID_WIDTH-1:0]        xif_commit_id,
    output logic                       xif_commit_kill,
    input  logic                       xif_result_valid,
    output logic                       xif_result_ready,
    input  logic [ID_WIDTH-1:0]        xif_result_id,
    input  logic [4:0]                 xif_result_rd,
    input  logic                       xif_result_we,
    input  logic [XLEN-1:0]            xif_result_data,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic                       err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ID_WIDTH-1:0] q_id [DEPTH];
    logic [DEPTH-1:0]    q_wb;
    logic [DEPTH-1:0]    q_cm;
    logic [DEPTH-1:0]    q_kl;
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [CW-1:0]       count;
    logic [CW-1:0]       n_cm;
    logic [ID_WIDTH-1:0] id_cnt;
    logic [PW-1:0]       cm_idx;
    logic                nonempty, issue_hs, push, head_ck, res_hs, res_ok, pop, cm_ok, wb_fire;

    assign nonempty          = (count != '0);
    assign stall             = (count == CW'(DEPTH));
    assign xif_issue_valid   = core_issue_valid & ~stall;
    assign core_issue_ready  = xif_issue_ready & ~stall;
    assign issue_hs          = core_issue_valid & core_issue_ready;
    assign core_issue_accept = issue_hs & xif_resp_accept;
    assign push              = core_issue_accept;
    assign xif_issue_instr   = core_issue_instr;
    assign xif_issue_rs1     = core_rs1;
    assign xif_issue_rs2     = core_rs2;
    assign xif_issue_id      = id_cnt;
    assign outstanding       = count;

    // Committed entries always form a prefix of the queue, so the oldest
    // uncommitted entry sits n_cm slots behind the head.
    assign cm_idx           = head + n_cm[PW-1:0];
    assign cm_ok            = core_commit_valid & (n_cm < count);
    assign head_ck          = nonempty & q_cm[head] & q_kl[head];
    assign xif_result_ready = nonempty & ~head_ck;
    assign res_hs           = xif_result_valid & xif_result_ready;
    assign res_ok           = res_hs & q_cm[head] & (xif_result_id == q_id[head]);
    assign pop              = head_ck | res_ok;
    assign wb_fire          = res_ok & xif_result_we & q_wb[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            n_cm             <= '0;
            id_cnt           <= '0;
            err              <= 1'b0;
            q_cm             <= '0;
            q_kl             <= '0;
            xif_commit_valid <= 1'b0;
            xif_commit_id    <= '0;
            xif_commit_kill  <= 1'b0;
            core_wb_valid    <= 1'b0;
            core_wb_rd       <= '0;
            core_wb_data     <= '0;
        end else begin
            if (issue_hs) id_cnt <= id_cnt + ID_WIDTH'(1);
            if (push) begin
                tail       <= tail + PW'(1);
                q_cm[tail] <= 1'b0;
                q_kl[tail] <= 1'b0;
            end
            // A push never lands on cm_idx: the queue cannot be full while pushing.
            if (cm_ok) begin
                q_cm[cm_idx] <= 1'b1;
                q_kl[cm_idx] <= core_commit_kill;
            end
            if (pop) head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            n_cm  <= n_cm + CW'(cm_ok) - CW'(pop);

            xif_commit_valid <= cm_ok;
            if (cm_ok) begin
                xif_commit_id   <= q_id[cm_idx];
                xif_commit_kill <= core_commit_kill;
            end
            core_wb_valid <= wb_fire;
            if (wb_fire) begin
                core_wb_rd   <= xif_result_rd;
                core_wb_data <= xif_result_data;
            end
            if ((core_commit_valid & ~cm_ok) | (res_hs & ~res_ok)) err <= 1'b1;
        end
    end

    // Entry payload needs no reset: only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            q_id[tail] <= id_cnt;
            q_wb[tail] <= xif_resp_writeback;
        end
    end

endmodule

// File: doc/srv32_xif_tracker.md
# srv32_xif_tracker

Parametrised CV-X-IF offload tracker placed between the srv32 core and a vector coprocessor. It forwards issue requests and assigns transaction IDs. It keeps an in-order queue of accepted offloaded instructions and turns core retire/kill events into XIF commit transactions. Returned results are matched against the oldest entry and written back into the core register file.

## Interface
- DEPTH, 4, outstanding-entry capacity; power of two, at least 2.
- ID_WIDTH, 4, XIF transaction ID width; at least log2(DEPTH)+1.
- XLEN, 32, operand/result width.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- core_issue_valid  in  1  core offers an instruction.
- core_issue_instr  in  32  instruction word.
- core_rs1, core_rs2  in  XLEN  source operands.
- core_issue_ready  out  1  issue handshake completes this cycle.
- core_issue_accept  out  1  coprocessor accepted (valid with ready).
- core_commit_valid  in  1  core retires or kills the oldest uncommitted offload.
- core_commit_kill  in  1  qualifies commit as kill.
- core_wb_valid  out  1  register writeback strobe; core never back-pressures.
- core_wb_rd  out  5  destination register.
- core_wb_data  out  XLEN  writeback data.
- stall  out  1  queue full.
- xif_issue_valid  out  1, xif_issue_ready  in  1.
- xif_issue_instr  out  32, xif_issue_rs1/rs2  out  XLEN, xif_issue_id  out  ID_WIDTH.
- xif_resp_accept  in  1, xif_resp_writeback  in  1  issue response, sampled at handshake.
- xif_commit_valid  out  1, xif_commit_id  out  ID_WIDTH, xif_commit_kill  out  1.
- xif_result_valid  in  1, xif_result_ready  out  1.
- xif_result_id  in  ID_WIDTH, xif_result_rd  in  5, xif_result_we  in  1, xif_result_data  in  XLEN.
- outstanding  out  log2(DEPTH)+1  entries in the queue.
- err  out  1  sticky protocol error.

## Operation
- Issue path is combinational. xif_issue_valid = core_issue_valid & ~stall. core_issue_ready = xif_issue_ready & ~stall. Instr and operands pass straight through.
- core_issue_accept = xif_resp_accept during the handshake.
- stall = (outstanding == DEPTH). A pop in the same cycle does not lift stall.
- ID counter: xif_issue_id equals the counter value. It increments by 1 on every issue handshake, accepted or not, and wraps modulo 2^ID_WIDTH.
- Handshake with accept=1 pushes an entry at the tail: {id, wb = xif_resp_writeback, committed = 0, killed = 0}. Accept=0 pushes nothing.
- core_commit_valid marks the oldest uncommitted entry as committed, with killed = core_commit_kill.
  - The next cycle emits xif_commit_valid with that entry's id and kill bit.
  - If no uncommitted entry exists, the commit is ignored and err is set.
- Head pop, at most one per cycle:
  - (a) Head committed and killed: pop, no writeback.
  - (b) Result handshake whose id equals the head id, with head committed and not killed: pop. The next cycle pulses core_wb_valid with rd and data, but only if xif_result_we & head.wb. Otherwise no writeback.
- xif_result_ready = 1 whenever the queue is non-empty and the head is not (committed & killed). Any other result handshake (empty queue, id mismatch, head uncommitted) is dropped and sets err.
- Push and pop in the same cycle: outstanding stays unchanged; pointers wrap modulo DEPTH.
- Commit marking and pop of the same entry in one cycle is not possible, because pop requires the committed state already registered.

## Timing
- Reset values:
  - Outputs: all registered outputs are 0.
  - Internal state: ID counter 0, pointers 0, err 0.
  - Combinational outputs: xif_issue_valid follows core_issue_valid, and ready follows xif_issue_ready.
- Reset mid-operation flushes the queue immediately. No commit or writeback is emitted for flushed entries.
- Issue latency is 0 cycles. Commit latency is 1 cycle after core_commit_valid. Writeback latency is 1 cycle after the result handshake.
- Killed-head pop occurs in the first cycle in which the registered head state shows committed & killed.
- outstanding and stall update on the clock edge after push or pop.

## Test plan
- Single offload: issue instr 0x0000_0057 with id 0, accept=1, wb=1, then commit (kill=0). Next cycle: xif_commit_valid with id 0. Then result id 0, rd 5, data 0xDEAD_BEEF, we=1. Next cycle: core_wb_valid, rd 5, data 0xDEAD_BEEF; outstanding returns to 0.
- Fill: DEPTH=4, four accepted issues. stall=1 and core_issue_ready=0 on the fifth. One retire frees a slot one cycle later, and the next issue carries id 4.
- Reject and wrap: 17 handshakes with accept=0. Nothing is pushed, and the ID counter reads 1 after wrapping from 15.
- Kill: two accepted entries; commit the first with kill=1. xif_commit_kill=1 is emitted, the head pops without writeback, and entry 2 becomes head.
- Error: result id 3 while the head id is 2 → result dropped, err=1 and stays 1. Commit on an empty queue also sets err.
- Reset mid-flight: with 3 entries outstanding, assert reset. outstanding=0, no xif_commit_valid and no core_wb_valid are emitted, and the next issue carries id 0.
